serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Multi-cycle sequencer that computes WIDTH-bit add/subtract results by stepping operands through one shared 4-bit ripple adder slice, least-significant nibble first. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. The narrow adder is reused, so a wide result costs NIBBLES cycles rather than a wide carry chain.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8
- NIBBLES, WIDTH/4, derived localparam; number of adder passes
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain only
- in_valid  in  1  operand request valid
- in_ready  out  1  controller can accept operands
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- sub  in  1  1 = A − B, 0 = A + B; sampled with the operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result, modulo 2^WIDTH
- c_out  out  1  carry out of the MSB; for subtraction, 1 = no borrow
- overflow  out  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load a_q ← a, b_q ← (sub ? ~b : b), carry_q ← sub, cnt ← 0, sum_q ← 0.
  - Latch msb_a ← a[WIDTH−1] and msb_b ← effective b[WIDTH−1]. Go to RUN.
- RUN, one nibble per cycle:
  - The slice adds a_q[3:0] + b_q[3:0] + carry_q.
  - carry_q ← slice carry out.
  - sum_q ← {slice sum, sum_q[WIDTH−1:4]}.
  - a_q and b_q shift right by 4.
  - cnt increments. When cnt == NIBBLES−1, go to DONE.
- DONE:
  - out_valid = 1. sum = sum_q, c_out = carry_q.
  - overflow = (msb_a == msb_b) & (sum_q[WIDTH−1] != msb_a).
  - Outputs hold stable while out_ready = 0.
  - On out_ready, go to IDLE.
- in_ready = 0 in RUN and DONE. An in_valid asserted then is ignored; the producer holds its request.
- sum, c_out and overflow equal 0 whenever out_valid = 0. They are gated, not left over from a previous result.
- Wrap-around: the result is modulo 2^WIDTH. Carry out of the top nibble appears only on c_out.
- Corner cases:
  - a = b = 0 with sub = 1 gives sum = 0, c_out = 1.
  - Max + max gives sum = 2^WIDTH − 2, c_out = 1.

## Timing
- Reset (rst_n low, asynchronous assert, any state):
  - State becomes IDLE; cnt, a_q, b_q, sum_q, carry_q, msb_a, msb_b all become 0.
  - Outputs: in_ready = 0 while rst_n is low, 1 from the first cycle after release. out_valid = 0, sum = 0, c_out = 0, overflow = 0.
  - Reset mid-RUN or mid-DONE discards the operation; no result is ever delivered.
- Latency:
  - Accept edge T0.
  - RUN occupies T0+1 … T0+NIBBLES.
  - out_valid is first high in cycle T0+NIBBLES+1.
- Throughput: when out_ready is tied high, one operation every NIBBLES+2 cycles, including one idle accept cycle.
- Handshake:
  - A transfer occurs on the rising edge where valid & ready are both high.
  - out_valid, once high, stays high until the transfer edge.
- All outputs are registered or decoded from state only. in_ready and out_valid have no combinational path from in_valid or out_ready.

## Structure
- Shared package serial_add_pkg holds:
  - the state enum type (IDLE/RUN/DONE, 2 bits);
  - the constant NIBBLE_W = 4.
- One sub-module, nibble_adder: purely combinational 4-bit ripple adder with a, b, c_in, s, c_out.
  - Instantiated once, fed from a_q[3:0], b_q[3:0], carry_q.
- Controller RTL covers the FSM, nibble counter ($clog2(NIBBLES) bits), operand/result shift registers and output gating.

## Test plan
- Reset, then add:
  - Check reset values on all outputs.
  - With out_ready held high, apply a = 16'h1234, b = 16'h4321, sub = 0.
  - Expect in_ready = 1 in the first cycle after rst_n releases.
  - Expect sum = 16'h5555, c_out = 0, overflow = 0, out_valid exactly 5 cycles after the accept edge.
- Carry/wrap: a = 16'hFFFF, b = 16'h0001, add → sum = 16'h0000, c_out = 1, overflow = 0.
- Subtract, both signs:
  - a = 16'h0005, b = 16'h0007 → sum = 16'hFFFE, c_out = 0 (borrow).
  - a = 16'h8000, b = 16'h0001 → sum = 16'h7FFF, overflow = 1.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid.
  - Expect sum, c_out, overflow and out_valid stable throughout, and in_ready = 0.
  - Release out_ready → IDLE the next cycle; a queued in_valid is accepted then.
- Reset mid-operation:
  - Assert rst_n low during the second RUN cycle.
  - Expect all outputs 0 immediately (asynchronous), no out_valid after release, and correct results for a fresh a = 16'h00FF, b = 16'h0001 (sum = 16'h0100).
- Random regression: 1000 random a/b/sub with random out_ready and in_valid gaps, compared against a reference model for sum, c_out and overflow.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types for the nibble-serial adder.
// FSM state encoding and adder slice width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry adder slice.
// Ports: a, b, c_in in; s, c_out out.
module nibble_adder
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic                c_out
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = c[NIBBLE_W];

endmodule

// File: rtl/serial_adder_ctrl.sv
// WIDTH-bit add/sub sequenced through one 4-bit slice, LS nibble first.
// Ports: in_valid/in_ready/a/b/sub in; out_valid/out_ready/sum/c_out/overflow out.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              msb_a_q, msb_a_d;
  logic              msb_b_q, msb_b_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_c;

  nibble_adder u_slice (
    .a     (a_q[NIBBLE_W-1:0]),
    .b     (b_q[NIBBLE_W-1:0]),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    msb_a_d = msb_a_q;
    msb_b_d = msb_b_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract as a + ~b + 1: the +1 rides in as carry-in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          sum_d   = '0;
          msb_a_d = a[WIDTH-1];
          msb_b_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = slice_c;
        sum_d   = {slice_s, sum_q[WIDTH-1:NIBBLE_W]};
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
    end
  end

  // in_ready is forced low while reset is held.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = out_valid ? sum_q : '0;
  assign c_out     = out_valid & carry_q;
  assign overflow  = out_valid & (msb_a_q == msb_b_q)
                   & (sum_q[WIDTH-1] != msb_a_q);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl.
// Vector table, backpressure/reset sequences, random regression.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vs;
    logic [15:0] es;
    logic        ec;
    logic        eo;
    int          hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] va, input logic [15:0] vb,
                          input logic vs, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    a = va;
    b = vb;
    sub = vs;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) chk("accept_timeout", 32'(t), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called in the first cycle after the accept edge.
  task automatic get_result(input logic [15:0] es, input logic ec,
                            input logic eo, input int hold,
                            input string nm);
    int n;
    n = 1;
    while (!out_valid && n < 50) begin
      chk({nm, "_gated"}, {15'd0, sum, c_out, overflow}, 0);
      chk({nm, "_busy"}, 32'(in_ready), 0);
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_valid"}, 32'(out_valid), 1);
    chk({nm, "_lat"}, 32'(n), 5);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(c_out), 32'(ec));
    chk({nm, "_ovf"}, 32'(overflow), 32'(eo));
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk({nm, "_hold"}, {13'd0, out_valid, in_ready, sum, c_out, overflow},
            {13'd0, 1'b1, 1'b0, es, ec, eo});
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({nm, "_xfer"}, {14'd0, out_valid, in_ready, sum},
        {14'd0, 1'b0, 1'b1, 16'd0});
  endtask

  vec_t vecs[8];

  initial begin
    logic [15:0] ra, rb, rs;
    logic        rsub, rc, ro;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 2};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0};
    vecs[7] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b1, 3};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;
    #1;
    chk("rst_outs", {13'd0, in_ready, out_valid, sum, c_out, overflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].va, vecs[i].vb, vecs[i].vs, 0);
      get_result(vecs[i].es, vecs[i].ec, vecs[i].eo, vecs[i].hold,
                 $sformatf("vec%0d", i));
    end

    // Backpressure with a queued request.
    start_op(16'hA000, 16'h0123, 1'b0, 0);
    while (!out_valid) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    a = 16'h0F0F;
    b = 16'h0101;
    sub = 1'b0;
    in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {13'd0, out_valid, in_ready, sum, c_out, overflow},
          {13'd0, 1'b1, 1'b0, 16'hA123, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accepted", 32'(in_ready), 0);
    get_result(16'h1010, 1'b0, 1'b0, 0, "bp_queued");

    // Reset during the second RUN cycle.
    start_op(16'h1111, 16'h2222, 1'b0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {13'd0, in_ready, out_valid, sum, c_out, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", 32'(in_ready), 1);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("mid_rst_novalid", 32'(out_valid), 0);
    end
    start_op(16'h00FF, 16'h0001, 1'b0, 0);
    get_result(16'h0100, 1'b0, 1'b0, 0, "post_rst");

    // Random regression against an arithmetic reference.
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rsub = 1'($urandom);
      if (rsub) begin
        rs = ra - rb;
        rc = (ra >= rb);
        ro = (ra[15] != rb[15]) && (rs[15] != ra[15]);
      end else begin
        {rc, rs} = {1'b0, ra} + {1'b0, rb};
        ro = (ra[15] == rb[15]) && (rs[15] != ra[15]);
      end
      start_op(ra, rb, rsub, $urandom_range(0, 3));
      get_result(rs, rc, ro, $urandom_range(0, 3), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
